// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory port arbiter.
// Optional watchdog feature is selected with the MEM_ARB_TIMEOUT_EN macro.
package mem_arb_pkg;

   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 255;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IF_BUSY = 2'd1,
      D_BUSY  = 2'd2
   } state_t;

   // Owner of the most recently completed memory transaction
   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } gnt_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for the memory port arbiter.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_watchdog
   import mem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
)(
   input  logic clk,
   input  logic nrst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   // At least 8 bits, wider if the limit needs it
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

   logic [CNT_W-1:0] r_cnt;

   // Expires in the TIMEOUT_CYCLES-th enabled cycle after a clear
   assign expire = en && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   // Count enabled cycles, restart from zero on clear
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (en && !expire) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// Round-robin on ties, registered memory-side outputs, one-cycle ack pulses.
// Define MEM_ARB_TIMEOUT_EN to add the busy watchdog and the sticky err output.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
)(
   input  logic              clk,
   input  logic              nrst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              cpu_stall
`ifdef MEM_ARB_TIMEOUT_EN
  ,output logic              err
`endif
);

   state_t            r_state;
   state_t            w_state_nxt;
   gnt_t              r_last_grant;

   logic              r_mem_req;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_if_ack;
   logic              r_d_ack;

   logic              w_if_pend;
   logic              w_d_pend;
   logic              w_gnt_if;
   logic              w_gnt_d;
   logic              w_done;
   logic              w_expire;
   logic              w_timeout;

   // A requester being acked this cycle is not considered pending
   assign w_if_pend = if_req & ~r_if_ack;
   assign w_d_pend  = d_req  & ~r_d_ack;
   assign cpu_stall = w_if_pend | w_d_pend;

   assign w_timeout = w_expire & ~mem_ready;

`ifdef MEM_ARB_TIMEOUT_EN
   logic r_err;

   mem_arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (r_state == IDLE),
      .en     (r_state != IDLE),
      .expire (w_expire)
   );

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_err <= 1'b0;
      end else if (w_done && w_timeout) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign w_expire = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and grant/complete decisions
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_if    = 1'b0;
      w_gnt_d     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_if_pend && w_d_pend) begin
               if (r_last_grant == GNT_IF) begin
                  w_gnt_d = 1'b1;
               end else begin
                  w_gnt_if = 1'b1;
               end
            end else if (w_if_pend) begin
               w_gnt_if = 1'b1;
            end else if (w_d_pend) begin
               w_gnt_d = 1'b1;
            end
            if (w_gnt_if) begin
               w_state_nxt = IF_BUSY;
            end else if (w_gnt_d) begin
               w_state_nxt = D_BUSY;
            end
         end
         IF_BUSY, D_BUSY: begin
            if (mem_ready || w_expire) begin
               w_done      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Memory-side outputs, read data capture, ack pulses and round-robin history
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_if_rdata   <= '0;
         r_d_rdata    <= '0;
         r_if_ack     <= 1'b0;
         r_d_ack      <= 1'b0;
         r_last_grant <= GNT_IF;
      end else begin
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
         if (w_gnt_if) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= if_addr;
         end else if (w_gnt_d) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= d_we;
            r_mem_addr  <= d_addr;
            r_mem_wdata <= d_wdata;
         end else if (w_done) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_state == IF_BUSY) begin
               r_if_ack     <= 1'b1;
               r_last_grant <= GNT_IF;
               r_if_rdata   <= w_timeout ? '0 : mem_rdata;
            end else begin
               r_d_ack      <= 1'b1;
               r_last_grant <= GNT_D;
               if (w_timeout) begin
                  r_d_rdata <= '0;
               end else if (!r_mem_we) begin
                  r_d_rdata <= mem_rdata;
               end
            end
         end
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign if_rdata  = r_if_rdata;
   assign d_rdata   = r_d_rdata;
   assign if_ack    = r_if_ack;
   assign d_ack     = r_d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter.
// Timeout scenario is included when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          nrst;
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          cpu_stall;
`ifdef MEM_ARB_TIMEOUT_EN
   logic          err;
`endif

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .cpu_stall (cpu_stall)
`ifdef MEM_ARB_TIMEOUT_EN
     ,.err       (err)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req    = 1'b0;
      if_addr   = '0;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = '0;
      d_wdata   = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      idle_inputs();
      #3;
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0h want=0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_we got=%0h want=0", mem_we); end
      checks++; if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
      checks++; if ({if_ack, d_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b want=00", {if_ack, d_ack}); end
      checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", if_rdata, d_rdata); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h want=0", cpu_stall); end
`ifdef MEM_ARB_TIMEOUT_EN
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0h want=0", err); end
`endif
      tick();
      tick();
      nrst = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      if_req  = 1'b1;
      if_addr = 32'h0000_0004;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin failures++; $display("FAIL fetch_stall_req got=%0h want=1", cpu_stall); end
      tick();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_mem_req got=%0h want=1", mem_req); end
      checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL fetch_mem_we got=%0h want=0", mem_we); end
      checks++; if (mem_addr !== 32'h0000_0004) begin failures++; $display("FAIL fetch_mem_addr got=%h want=00000004", mem_addr); end
      checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL fetch_early_ack got=%0h want=0", if_ack); end
      mem_ready = 1'b1;
      mem_rdata = 32'h2008_0005;
      tick();
      checks++; if (if_ack !== 1'b1) begin failures++; $display("FAIL fetch_ack got=%0h want=1", if_ack); end
      checks++; if (if_rdata !== 32'h2008_0005) begin failures++; $display("FAIL fetch_rdata got=%h want=20080005", if_rdata); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL fetch_mem_req_drop got=%0h want=0", mem_req); end
      checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL fetch_no_d_ack got=%0h want=0", d_ack); end
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL fetch_stall_ack got=%0h want=0", cpu_stall); end
      mem_ready = 1'b0;
      if_req    = 1'b0;
      tick();
      checks++; if (if_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_pulse got=%0h want=0", if_ack); end
   endtask

   task automatic test_store();
      int acks;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0010;
      d_wdata = 32'hDEAD_BEEF;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin failures++; $display("FAIL store_ctrl_c%0d got=%b%b want=11", i, mem_req, mem_we); end
         checks++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL store_data_c%0d got=%h/%h want=00000010/deadbeef", i, mem_addr, mem_wdata); end
         checks++; if (d_ack !== 1'b0) begin failures++; $display("FAIL store_early_ack_c%0d got=%0h want=0", i, d_ack); end
         if (i == 3) begin
            mem_ready = 1'b1;
            mem_rdata = 32'h1234_5678;
         end
         tick();
      end
      mem_ready = 1'b0;
      acks = 0;
      checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL store_stall_ack got=%0h want=0", cpu_stall); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL store_mem_req_drop got=%0h want=0", mem_req); end
      checks++; if (d_rdata !== 32'h0) begin failures++; $display("FAIL store_rdata_kept got=%h want=00000000", d_rdata); end
      if (d_ack === 1'b1) acks++;
      d_req = 1'b0;
      d_we  = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         if (d_ack === 1'b1) acks++;
      end
      checks++; if (acks != 1) begin failures++; $display("FAIL store_ack_count got=%0d want=1", acks); end
   endtask

   task automatic test_load();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h0000_0020;
      tick();
      checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h20) begin failures++; $display("FAIL load_mem got=%0h/%h want=0/00000020", mem_we, mem_addr); end
      mem_ready = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ready = 1'b0;
      d_req     = 1'b0;
      checks++; if (d_ack !== 1'b1) begin failures++; $display("FAIL load_ack got=%0h want=1", d_ack); end
      checks++; if (d_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL load_rdata got=%h want=cafef00d", d_rdata); end
      tick();
   endtask

   task automatic test_ready_idle();
      mem_ready = 1'b1;
      mem_rdata = 32'h5555_5555;
      tick();
      tick();
      checks++; if ({if_ack, d_ack} !== 2'b00) begin failures++; $display("FAIL idle_ready_acks got=%b want=00", {if_ack, d_ack}); end
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_ready_mem_req got=%0h want=0", mem_req); end
      checks++; if (if_rdata !== 32'h2008_0005 || d_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL idle_ready_rdata got=%h/%h want=20080005/cafef00d", if_rdata, d_rdata); end
      mem_ready = 1'b0;
      // FSM must still be in IDLE and serve a fresh fetch with normal latency
      if_req  = 1'b1;
      if_addr = 32'h0000_0008;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin failures++; $display("FAIL idle_ready_grant got=%0h/%h want=1/00000008", mem_req, mem_addr); end
      mem_ready = 1'b1;
      mem_rdata = 32'h0000_0011;
      tick();
      mem_ready = 1'b0;
      if_req    = 1'b0;
      checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h11) begin failures++; $display("FAIL idle_ready_fetch got=%0h/%h want=1/00000011", if_ack, if_rdata); end
      tick();
   endtask

   task automatic test_round_robin();
      logic          exp_d;
      logic [AW-1:0] exp_addr;
      nrst = 1'b0;
      #2;
      nrst = 1'b1;
      tick();
      if_req  = 1'b1;
      if_addr = 32'h0000_0100;
      d_req   = 1'b1;
      d_we    = 1'b0;
      d_addr  = 32'h0000_0200;
      for (int k = 0; k < 4; k++) begin
         exp_d    = (k % 2 == 0);
         exp_addr = exp_d ? 32'h200 : 32'h100;
         tick();
         checks++; if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin failures++; $display("FAIL rr_grant_%0d got=%0h/%h want=1/%h", k, mem_req, mem_addr, exp_addr); end
         mem_ready = 1'b1;
         mem_rdata = 32'hA0 + k;
         tick();
         mem_ready = 1'b0;
         checks++; if ({d_ack, if_ack} !== {exp_d, ~exp_d}) begin failures++; $display("FAIL rr_ack_%0d got=%b want=%b", k, {d_ack, if_ack}, {exp_d, ~exp_d}); end
         checks++; if ((exp_d ? d_rdata : if_rdata) !== 32'hA0 + k) begin failures++; $display("FAIL rr_rdata_%0d got=%h want=%h", k, (exp_d ? d_rdata : if_rdata), 32'hA0 + k); end
         if (k == 3) begin
            if_req = 1'b0;
            d_req  = 1'b0;
         end
      end
      tick();
      checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rr_idle got=%0h want=0", mem_req); end
   endtask

   task automatic test_reset_mid();
      int acks;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h0000_0040;
      d_wdata = 32'h0BAD_F00D;
      tick();
      checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_busy got=%0h want=1", mem_req); end
      nrst = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL rstmid_async_drop got=%b%b want=00", mem_req, mem_we); end
      d_req = 1'b0;
      d_we  = 1'b0;
      acks  = 0;
      tick();
      if (d_ack === 1'b1) acks++;
      nrst = 1'b1;
      tick();
      if (d_ack === 1'b1) acks++;
      checks++; if (acks != 0 || mem_req !== 1'b0) begin failures++; $display("FAIL rstmid_no_ack got=%0d/%0h want=0/0", acks, mem_req); end
      // last_grant back to IF: data must win the next tie
      if_req  = 1'b1;
      if_addr = 32'h0000_0300;
      d_req   = 1'b1;
      d_addr  = 32'h0000_0400;
      tick();
      checks++; if (mem_addr !== 32'h400) begin failures++; $display("FAIL rstmid_tie_winner got=%h want=00000400", mem_addr); end
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      if_req    = 1'b0;
      d_req     = 1'b0;
      checks++; if (d_ack !== 1'b1) begin failures++; $display("FAIL rstmid_tie_ack got=%0h want=1", d_ack); end
      tick();
   endtask

`ifdef MEM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      if_req    = 1'b1;
      if_addr   = 32'h0000_0080;
      mem_ready = 1'b0;
      mem_rdata = 32'hFFFF_FFFF;
      tick();
      for (int i = 1; i < 8; i++) begin
         tick();
         checks++; if (mem_req !== 1'b1 || if_ack !== 1'b0) begin failures++; $display("FAIL to_wait_c%0d got=%b%b want=10", i, mem_req, if_ack); end
      end
      tick();
      if_req = 1'b0;
      checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0) begin failures++; $display("FAIL to_abort got=%0h/%h want=1/00000000", if_ack, if_rdata); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_set got=%0h want=1", err); end
      tick();
      tick();
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%0h want=1", err); end
      nrst = 1'b0;
      #1;
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL to_err_clear got=%0h want=0", err); end
      nrst = 1'b1;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_fetch();
      test_store();
      test_load();
      test_ready_idle();
      test_round_robin();
      test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-ported unified memory between the CPU's instruction-fetch port and its load/store port. It sits between the PC/instruction path and the data-memory path on one side and the memory on the other. It serialises transactions with a req/ack handshake on each requester and a req/ready handshake toward memory. It drives `cpu_stall` so the PC register and register bank hold while an access is outstanding.

## Interface
- `ADDR_W`, default 32: address width on all ports.
- `DATA_W`, default 32: data width on all ports.
- `TIMEOUT_CYCLES`, default 255: watchdog limit, used only when `MEM_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `nrst`  in  1  reset, asynchronous and active-low.
- `if_req`  in  1  fetch request; held until `if_ack`.
- `if_addr`  in  ADDR_W  fetch address (PC); stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetched instruction; valid when `if_ack` is high.
- `if_ack`  out  1  one-cycle fetch completion pulse.
- `d_req`  in  1  load/store request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  ALU-computed data address.
- `d_wdata`  in  DATA_W  store data.
- `d_rdata`  out  DATA_W  load data; valid when `d_ack` is high.
- `d_ack`  out  1  one-cycle data completion pulse.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  registered memory address.
- `mem_wdata`  out  DATA_W  registered write data.
- `mem_rdata`  in  DATA_W  memory read data; valid with `mem_ready`.
- `mem_ready`  in  1  memory completes the current transaction.
- `cpu_stall`  out  1  high whenever any request is pending and not yet acked.
- `err`  out  1  sticky timeout flag. Present only with `MEM_ARB_TIMEOUT_EN`.

## Operation
- FSM states are IDLE, IF_BUSY, D_BUSY.
- IDLE:
  - Grant to the pending requester.
  - If both are pending, grant by round-robin: the requester not served last wins.
  - `last_grant` resets to IF, so data wins the first tie after reset.
  - On grant, register the address, we and wdata into the `mem_*` outputs, assert `mem_req`, and move to IF_BUSY or D_BUSY.
  - A fetch grant always drives `mem_we`=0.
- BUSY:
  - Hold all `mem_*` outputs stable until `mem_ready`.
  - On `mem_ready`, capture `mem_rdata` into `if_rdata` or `d_rdata`, pulse the matching ack next cycle, drop `mem_req`, update `last_grant`, and return to IDLE.
  - On a store, `d_rdata` is left unchanged.
- In the ack cycle, the acked requester's `req` is ignored; it may re-request from the following cycle.
- `cpu_stall` = (`if_req` & ~`if_ack`) | (`d_req` & ~`d_ack`), combinational.
- Reset values:
  - State IDLE, `last_grant` IF.
  - All outputs 0: `mem_*`, both acks, both rdata, `err`.
- Reset asserted mid-transaction abandons it: no ack is issued and `mem_req` drops immediately (asynchronous).
- `mem_ready` outside BUSY is ignored.
- Requests arriving in a BUSY state wait; nothing is queued beyond the req level.

## Timing
- Grant latency: a request sampled in IDLE at edge N gives `mem_req` high after edge N.
- Memory ready at edge M: `mem_req` is low and the ack pulses high during cycle M+1.
- Zero-wait-state memory (ready in the first BUSY cycle): 2 cycles from request to ack. Back-to-back throughput is one access per 3 cycles.
- With both requesters pending, the alternation is guaranteed: no requester waits more than one foreign transaction.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - An 8-bit+ counter runs in BUSY.
  - When it reaches `TIMEOUT_CYCLES` without `mem_ready`, the transaction is aborted: the ack is pulsed with rdata = 0, `err` is set (sticky until reset), and the FSM returns to IDLE.
- Macro undefined: no counter, no `err` port; BUSY waits indefinitely.

## Structure
- Shared package `mem_arb_pkg`:
  - state enum (IDLE, IF_BUSY, D_BUSY);
  - grant-owner encoding (GNT_IF, GNT_D);
  - default width constants.
- One natural sub-module, `mem_arb_watchdog`: the timeout counter with clear, enable and expire. It is instantiated only under `MEM_ARB_TIMEOUT_EN`.

## Test plan
- Fetch only, ready on first BUSY cycle, `if_addr`=0x0000_0004, `mem_rdata`=0x2008_0005 -> `if_ack` 2 cycles after request, `if_rdata`=0x2008_0005, `mem_we`=0.
- Store `d_addr`=0x10, `d_wdata`=0xDEAD_BEEF, ready after 3 wait cycles -> `mem_we`=1 and data held stable 4 cycles, `d_ack` once, `cpu_stall` low after ack.
- Simultaneous `if_req`/`d_req` held for 4 transactions -> grant order D, IF, D, IF.
- `nrst` pulled low in D_BUSY -> `mem_req`=0 immediately, no `d_ack`, state IDLE, `last_grant`=IF after release.
- `mem_ready` pulsed while IDLE -> no ack, no state change.
- With `MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `mem_ready` stuck low -> ack with rdata 0 after 8 BUSY cycles, `err`=1 until reset.
